alu_cc: RTL
===========

# alu_cc

Execute-stage ALU and condition-code register for the Y86 pipeline. Computes `valE` from the two ALU operands and the function code, derives the Zero/Sign/Overflow flags, and commits them into a 3-bit CC register when an `OPq` instruction is allowed to retire. The registered `ZSO` output drives the condition evaluator, which uses it for `jXX` and `cmovXX`.

## Interface
- `WIDTH`, default 64: operand and result width in bits.
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `aluA`, input, WIDTH: operand A (`valC` or `valA`).
- `aluB`, input, WIDTH: operand B (`valB` or 0).
- `alufun`, input, 4: 0 add, 1 sub, 2 and, 3 xor. 4..F are illegal.
- `set_cc`, input, 1: the E-stage instruction is `OPq` and requests a CC update.
- `m_exc`, input, 1: the M stage holds an exception (`SADR`/`SINS`/`SHLT`).
- `W_exc`, input, 1: the W stage holds an exception.
- `e_stall`, input, 1: the E stage is stalled, so the CC register holds its value.
- `valE`, output, WIDTH: ALU result. Combinational.
- `ZSO`, output, 3: registered flags. [2]=ZF, [1]=SF, [0]=OF.
- `cc_wr`, output, 1: registered pulse, high for the one cycle after a CC commit.
- `alu_err`, output, 1: combinational. High when `alufun` is illegal.

## Operation
- `valE`:
  - add = B+A
  - sub = B−A
  - and = B&A
  - xor = B^A
  - Result is truncated to WIDTH; there is no carry out.
  - Illegal `alufun` gives `valE`=0 and `alu_err`=1.
- Next flags, computed from the result t (WIDTH bits):
  - ZF = (t==0).
  - SF = t[WIDTH-1].
  - OF for add = (A[msb]==B[msb]) & (t[msb]!=A[msb]).
  - OF for sub = (A[msb]!=B[msb]) & (t[msb]!=B[msb]).
  - OF for and/xor = 0.
- Commit condition: `commit = set_cc & ~m_exc & ~W_exc & ~e_stall & ~alu_err`.
  - When `commit`=1, `ZSO` takes the next flags on the next edge and `cc_wr` goes to 1.
  - Otherwise `ZSO` holds and `cc_wr` goes to 0.
- Reset: `ZSO`=3'b100 (ZF=1, SF=0, OF=0, the Y86 power-on CC) and `cc_wr`=0.
  - `rst` overrides a `commit` in the same cycle.
  - A reset mid-program discards any pending update.
- An exception in M or W blocks the update for that cycle only. The update is not deferred. The younger instruction is squashed by pipeline control.
- Back-to-back `OPq` with `commit` on consecutive cycles: each edge loads the flags of the current instruction. There is no merging.

## Timing
- `valE` and `alu_err` are combinational from `aluA`/`aluB`/`alufun`, with zero latency.
- `ZSO` updates one edge after `commit` is sampled high. A `cmovXX`/`jXX` in the following E cycle sees the new flags.
- `cc_wr` is high for exactly one cycle after each commit edge.
- Inputs must be stable before the rising edge; the critical path is the ZF reduction.

## Structure
- Shared package `y86_pkg` holds:
  - `ALU_ADD`/`ALU_SUB`/`ALU_AND`/`ALU_XOR` constants.
  - `ZSO_Z`/`ZSO_S`/`ZSO_O` bit-index constants.
  - `CC_RESET`=3'b100.
  - The stat codes.
- One sub-module, `alu_core` (combinational): computes `valE`, the next flags and `alu_err`.
- The top level holds the CC register, the `cc_wr` flop and the commit logic.

## Test plan
- Reset: assert `rst` with `set_cc`=1 -> next cycle `ZSO`=100 and `cc_wr`=0.
- Add overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add, commit -> `valE`=0x8000_0000_0000_0000, `ZSO`=011, `cc_wr` pulses for 1 cycle.
- Sub to zero: A=5, B=5, sub, commit -> `valE`=0, `ZSO`=100. Then A=6, B=5, sub -> `valE`=−1, `ZSO`=010.
- Suppression: xor with a nonzero result and `set_cc`=1, driven once with `m_exc`=1, then once with `W_exc`=1, then once with `e_stall`=1 -> `ZSO` unchanged each time and `cc_wr`=0.
- Illegal op: `alufun`=4, `set_cc`=1 -> `valE`=0, `alu_err`=1, `ZSO` held.
- Back-to-back: add 1+1, then and 0xF0&0x0F, on consecutive committed cycles -> `ZSO`=000, then 100.

Source files
------------

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Brief    : Shared Y86 constants: ALU function codes, CC bit indices, stat codes.
// Revision : 1.0
// ============================================================================
package y86_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam int ZSO_Z = 2;
  localparam int ZSO_S = 1;
  localparam int ZSO_O = 0;

  // Y86 power-on condition codes: ZF set, SF/OF clear
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  function automatic logic alufun_legal(input logic [3:0] fun);
    return (fun == ALU_ADD) || (fun == ALU_SUB) || (fun == ALU_AND) || (fun == ALU_XOR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_cc_if
// Brief    : E-stage ALU operand/control bundle and its CC/result returns.
// Revision : 1.0
// ============================================================================
interface alu_cc_if #(
  parameter int WIDTH = 64
);

  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic [3:0]       alufun;
  logic             set_cc;
  logic             m_exc;
  logic             W_exc;
  logic             e_stall;
  logic [WIDTH-1:0] valE;
  logic [2:0]       ZSO;
  logic             cc_wr;
  logic             alu_err;

  modport master (
    output aluA, aluB, alufun, set_cc, m_exc, W_exc, e_stall,
    input  valE, ZSO, cc_wr, alu_err
  );

  modport slave (
    input  aluA, aluB, alufun, set_cc, m_exc, W_exc, e_stall,
    output valE, ZSO, cc_wr, alu_err
  );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Combinational Y86 ALU: result, next Z/S/O flags and illegal-op flag.
// Revision : 1.0
// ============================================================================
module alu_core
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  wire logic [WIDTH-1:0] aluA,
  input  wire logic [WIDTH-1:0] aluB,
  input  wire logic [3:0]       alufun,
  output logic      [WIDTH-1:0] valE,
  output logic      [2:0]       flags,
  output logic                  alu_err
);

  localparam int c_MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_t;
  logic             w_of;

  always_comb begin
    w_t     = '0;
    w_of    = 1'b0;
    alu_err = 1'b0;
    case (alufun)
      ALU_ADD: begin
        w_t  = aluB + aluA;
        w_of = (aluA[c_MSB] == aluB[c_MSB]) & (w_t[c_MSB] != aluA[c_MSB]);
      end
      ALU_SUB: begin
        w_t  = aluB - aluA;
        w_of = (aluA[c_MSB] != aluB[c_MSB]) & (w_t[c_MSB] != aluB[c_MSB]);
      end
      ALU_AND: w_t = aluB & aluA;
      ALU_XOR: w_t = aluB ^ aluA;
      default: alu_err = 1'b1;
    endcase
  end

  assign valE         = w_t;
  assign flags[ZSO_Z] = (w_t == '0);
  assign flags[ZSO_S] = w_t[c_MSB];
  assign flags[ZSO_O] = w_of;

endmodule
`default_nettype wire

// File: rtl/alu_cc.sv
`default_nettype none
// ============================================================================
// Module   : alu_cc
// Brief    : Execute-stage ALU with the Y86 condition-code register and commit gating.
// Revision : 1.0
// ============================================================================
module alu_cc
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  wire logic clk,
  input  wire logic rst,
  alu_cc_if.slave   bus
);

  logic [WIDTH-1:0] w_vale;
  logic [2:0]       w_flags;
  logic             w_err;
  logic             w_commit;
  logic [2:0]       r_zso;
  logic             r_cc_wr;

  alu_core #(
    .WIDTH   (WIDTH)
  ) u_core (
    .aluA    (bus.aluA),
    .aluB    (bus.aluB),
    .alufun  (bus.alufun),
    .valE    (w_vale),
    .flags   (w_flags),
    .alu_err (w_err)
  );

  // Exceptions and stalls drop the update outright; squashing is pipeline control's job
  assign w_commit = bus.set_cc & ~bus.m_exc & ~bus.W_exc & ~bus.e_stall & ~w_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zso   <= CC_RESET;
      r_cc_wr <= 1'b0;
    end else begin
      r_cc_wr <= w_commit;
      if (w_commit) begin
        r_zso <= w_flags;
      end
    end
  end

  assign bus.valE    = w_vale;
  assign bus.alu_err = w_err;
  assign bus.ZSO     = r_zso;
  assign bus.cc_wr   = r_cc_wr;

endmodule
`default_nettype wire
